spi_slave_resp: RTL

SPI slave/responder that sits on the far end of the SPI controller's serial bus.
- Receives words shifted out by the master on MOSI and returns words on MISO.
- Faces the local logic through valid/ready RX and TX streams.
- Runs in the system clock domain and oversamples the pad-level SCLK, SS and MOSI, so clk must be at least 8x the SCLK frequency.

---
 rtl/spi_slave_resp_if.sv | 37 +++
 rtl/spi_slave_resp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_resp_if.sv
// SPI responder bus: pad-level SPI pins, frame-mode controls, RX/TX valid-ready streams and status.
// Latency: n/a (signal bundle only).
// Backpressure: rx_ready stalls rx_valid; tx_ready low while the TX holding register is occupied.
// Modports: slave = responder view (spi_slave_resp), master = local logic plus SPI master model view.
interface spi_slave_resp_if #(
    parameter int DATA_W = 8
);
    logic              sclk_i;
    logic              ss_n_i;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe;
    logic              cpol;
    logic              cpha;
    logic              msb_first;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              overrun;
    logic              underrun;
    logic              clr_status;

    modport slave (
        input  sclk_i, ss_n_i, mosi_i, cpol, cpha, msb_first,
        input  rx_ready, tx_data, tx_valid, clr_status,
        output miso_o, miso_oe, rx_data, rx_valid, tx_ready, overrun, underrun
    );

    modport master (
        output sclk_i, ss_n_i, mosi_i, cpol, cpha, msb_first,
        output rx_ready, tx_data, tx_valid, clr_status,
        input  miso_o, miso_oe, rx_data, rx_valid, tx_ready, overrun, underrun
    );
endinterface

// File: rtl/spi_slave_resp.sv
// SPI slave responder: oversamples SCLK/SS/MOSI in the clk domain, returns words on MISO.
// Latency: 3 clk from a pad edge to its action; rx_valid rises 1 clk after the completing sample edge.
// Backpressure: rx word dropped (overrun) if rx_valid is still pending; TX_FILL sent (underrun) if no TX word held.
// Ports: clk, rst (async active-low), bus (spi_slave_resp_if.slave) carrying pads, RX/TX streams and status.
module spi_slave_resp #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] TX_FILL = '1
) (
    input  logic                clk,
    input  logic                rst,
    spi_slave_resp_if.slave     bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic              r_ss_s1, r_ss_s2, r_ss_d;
    logic              r_mosi_s1, r_mosi_s2;
    logic              r_cpol, r_cpha, r_msb;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_rx_sr, r_tx_sr, r_hold, r_rx_data;
    logic              r_hold_full, r_rx_valid, r_miso, r_fill_pend;
    logic              r_overrun, r_underrun;

    logic              w_sclk_rise, w_sclk_fall, w_ss_fall;
    logic              w_sample, w_shift, w_load, w_do_sample, w_do_shift;
    logic              w_word_done, w_rx_accept, w_ovr_set, w_unr_set, w_oe;
    logic [DATA_W-1:0] w_rx_next, w_reload_word;

    // Bit currently at the head of the TX shift register, and the register after popping it.
    function automatic logic f_front(input logic [DATA_W-1:0] v, input logic msb);
        return msb ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] f_adv(input logic [DATA_W-1:0] v, input logic msb);
        return msb ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
            r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_d   <= 1'b1;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= bus.sclk_i; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
            r_ss_s1   <= bus.ss_n_i; r_ss_s2   <= r_ss_s1;   r_ss_d   <= r_ss_s2;
            r_mosi_s1 <= bus.mosi_i; r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_ss_fall   = r_ss_d & ~r_ss_s2;
    // Sample on the rising edge when cpol==cpha, otherwise on the falling edge.
    assign w_sample    = (r_cpol == r_cpha) ? w_sclk_rise : w_sclk_fall;
    assign w_shift     = (r_cpol == r_cpha) ? w_sclk_fall : w_sclk_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // ACTIVE exits on the synced SS level, so a deassertion landing in the LOAD cycle is not lost.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_do_sample = 1'b0;
        w_do_shift  = 1'b0;
        case (r_state)
            IDLE:   if (w_ss_fall) w_state_nxt = LOAD;
            LOAD:   begin
                        w_load      = 1'b1;
                        w_state_nxt = ACTIVE;
                    end
            ACTIVE: begin
                        if (r_ss_s2) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_do_sample = w_sample;
                            w_do_shift  = w_shift;
                        end
                    end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_oe          = (r_state == ACTIVE);
    assign w_word_done   = w_do_sample && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_reload_word = r_hold_full ? r_hold : TX_FILL;
    assign w_rx_next     = r_msb ? {r_rx_sr[DATA_W-2:0], r_mosi_s2} : {r_mosi_s2, r_rx_sr[DATA_W-1:1]};
    assign w_rx_accept   = w_word_done && (!r_rx_valid || bus.rx_ready);
    assign w_ovr_set     = w_word_done && !w_rx_accept;
    // A fill word reloaded at word completion only counts as sent once the master clocks its first
    // bit; otherwise every single-word frame would flag an underrun at its final sample edge.
    assign w_unr_set     = (w_load && !r_hold_full) || (w_do_sample && r_fill_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpol <= 1'b0; r_cpha <= 1'b0; r_msb <= 1'b1;
            r_bit_cnt <= '0; r_rx_sr <= '0; r_tx_sr <= '0;
            r_hold <= '0; r_hold_full <= 1'b0;
            r_rx_data <= '0; r_rx_valid <= 1'b0;
            r_miso <= 1'b0; r_fill_pend <= 1'b0;
            r_overrun <= 1'b0; r_underrun <= 1'b0;
        end else begin
            // Holding register: consumed by a load/reload, refilled only while empty.
            if ((w_load || w_word_done) && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (bus.tx_valid && !r_hold_full) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                LOAD: begin
                    r_cpol      <= bus.cpol;
                    r_cpha      <= bus.cpha;
                    r_msb       <= bus.msb_first;
                    r_bit_cnt   <= '0;
                    r_rx_sr     <= '0;
                    r_fill_pend <= 1'b0;
                    // cpha=0 presents bit 0 before the first edge; cpha=1 waits for the first shift edge.
                    if (bus.cpha) begin
                        r_tx_sr <= w_reload_word;
                        r_miso  <= 1'b0;
                    end else begin
                        r_tx_sr <= f_adv(w_reload_word, bus.msb_first);
                        r_miso  <= f_front(w_reload_word, bus.msb_first);
                    end
                end
                ACTIVE: begin
                    if (r_ss_s2) begin
                        r_bit_cnt   <= '0;
                        r_rx_sr     <= '0;
                        r_miso      <= 1'b0;
                        r_fill_pend <= 1'b0;
                    end else if (w_do_sample) begin
                        r_rx_sr <= w_rx_next;
                        if (w_word_done) begin
                            r_bit_cnt   <= '0;
                            r_tx_sr     <= w_reload_word;
                            r_fill_pend <= !r_hold_full;
                        end else begin
                            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                            r_fill_pend <= 1'b0;
                        end
                    end else if (w_do_shift) begin
                        r_miso  <= f_front(r_tx_sr, r_msb);
                        r_tx_sr <= f_adv(r_tx_sr, r_msb);
                    end
                end
                default: r_miso <= 1'b0;
            endcase

            if (w_rx_accept) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end else if (bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // Set has priority over a coincident clear.
            if (w_ovr_set)           r_overrun  <= 1'b1;
            else if (bus.clr_status) r_overrun  <= 1'b0;
            if (w_unr_set)           r_underrun <= 1'b1;
            else if (bus.clr_status) r_underrun <= 1'b0;
        end
    end

    assign bus.miso_o   = r_miso & w_oe;
    assign bus.miso_oe  = w_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_ready = ~r_hold_full;
    assign bus.overrun  = r_overrun;
    assign bus.underrun = r_underrun;
endmodule
